control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have port Clock, input, 1 bit: single system clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port Stop, input, 1 bit: request to halt at the next instruction boundary.
REQ-004 The block SHALL have port IR, input, 32 bits: the datapath instruction register; fields are opcode[31:27], Ra[26:23], Rb[22:19] and Rc[18:15].
REQ-005 The block SHALL have port Run, output, 1 bit: high while the block is fetching or executing.
REQ-006 The block SHALL have output ports PCout, Zhighout, Zlowout, MDRout, HIout and LOout, 1 bit each: bus-driver selects.
REQ-007 The block SHALL have output ports PCin, MARin, MDRin, IRin, Yin, Zin, HIin and LOin, 1 bit each: register load enables.
REQ-008 The block SHALL have output ports IncPC and Read, 1 bit each: ALU PC-increment request and memory read strobe.
REQ-009 The block SHALL have output ports Rin and Rout, 16 bits each: one-hot general-purpose register load and drive vectors.
REQ-010 The block SHALL have port opcode, output, 5 bits: ALU operation select to the datapath.

Function
REQ-011 States SHALL be RST, T0, T1, T2, T3, T4, T5, T6 and HALT; each state SHALL last exactly one Clock cycle.
REQ-012 Outputs SHALL be Moore outputs decoded from the present state and IR only; any control not listed for a state SHALL be 0.
REQ-013 T0 SHALL assert PCout, MARin, IncPC and Zin.
REQ-014 T1 SHALL assert Zlowout, PCin, Read and MDRin.
REQ-015 T2 SHALL assert MDRout and IRin.
REQ-016 T3 SHALL assert Rout[IR.Rb] and Yin.
REQ-017 T4 SHALL assert Rout[IR.Rc], Zin, and opcode = IR[31:27].
REQ-018 T5 SHALL assert Zlowout together with Rin[IR.Ra] for ALU ops, or together with LOin for mul/div; T6 (mul/div only) SHALL assert Zhighout and HIin.
REQ-019 The decoded opcode classes SHALL be:
- ALU: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl, 01001 ror, 01010 rol
- mul/div: 01111 mul, 10000 div
- 11010 nop
- 11011 halt
- every other opcode is illegal.
REQ-020 Transitions SHALL be:
- RST->T0, T0->T1, T1->T2, T2->T3.
- From T3: ALU or mul/div -> T4; halt -> HALT; nop or illegal -> T0, with T3 asserting nothing.
- T4->T5.
- From T5: mul/div -> T6; ALU -> T0.
- T6->T0.
- HALT->HALT.
REQ-021 opcode SHALL be 00000 in every state other than T4.
REQ-022 At most one bus driver (PCout, Zhighout, Zlowout, MDRout, HIout, LOout or any Rout bit) SHALL be high in any cycle.
REQ-023 Rin and Rout SHALL each have at most one bit set.
REQ-024 A Stop seen high on any rising edge SHALL set a sticky stop_pending flag; the current instruction SHALL complete, and the transition that would enter T0 SHALL enter HALT instead.
REQ-025 Stop asserted in the same cycle as a T5/T6->T0 transition SHALL take effect on that transition.
REQ-026 Run SHALL be 1 in T0..T6 and 0 in RST and HALT; HALT SHALL be left only by Reset.
REQ-027 IR SHALL be sampled combinationally; IR changes outside T3..T6 SHALL have no effect on outputs.

Reset
REQ-028 While Reset=0, the state SHALL be RST immediately (asynchronously), every output SHALL be 0, Run SHALL be 0 and stop_pending SHALL be cleared.
REQ-029 The first rising edge with Reset=1 SHALL move the block RST->T0.
REQ-030 Reset asserted mid-instruction SHALL abort that instruction with no further control pulses.

Verification
REQ-031 IR=0x28918000 (and R1,R2,R3) after reset:
- T0..T5 in order.
- T3: Rout=0x0004, Yin=1.
- T4: Rout=0x0008, Zin=1, opcode=00101.
- T5: Zlowout=1, Rin=0x0002.
- Next cycle is T0.
REQ-032 IR=0x78118000 (mul): T5 has Zlowout=1, LOin=1, Rin=0; T6 has Zhighout=1, HIin=1; then T0; 7 cycles per instruction.
REQ-033 IR=0xD8000000 (halt): T3 goes to HALT; Run=0 and all controls are 0 for at least 10 cycles.
REQ-034 Stop pulsed for one cycle during T4 of an add (opcode 00011): T5 completes with Rin asserted, then HALT; Run falls.
REQ-035 Reset driven low during T4: all outputs are 0 before the next clock edge; after release, T0 follows with Run=1.
REQ-036 IR=0xF8000000 (illegal): T3 asserts nothing and the block returns to T0; Rin stays 0x0000 throughout; a checker confirms REQ-022 and REQ-023 in every cycle.

Source files
------------

// File: rtl/control_unit.sv
// Hardwired control sequencer for a single-bus datapath: fetch (T0-T2),
// operand/ALU steps (T3-T6), stop-at-boundary halting and async reset.
module control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stop,
  input  logic [31:0] IR,
  output logic        Run,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  opcode,
  output logic [3:0]  fsm_state
);

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       stop_pending;
  logic [4:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       is_alu;
  logic       is_muldiv;
  logic       is_halt;
  logic [3:0] boundary_state;
  logic       unused_ir;

  assign op = IR[31:27];
  assign ra = IR[26:23];
  assign rb = IR[22:19];
  assign rc = IR[18:15];
  // Low IR bits carry immediates the sequencer never looks at.
  assign unused_ir = ^IR[14:0];

  assign is_alu    = (op >= 5'd3) && (op <= 5'd10);
  assign is_muldiv = (op == 5'd15) || (op == 5'd16);
  assign is_halt   = (op == 5'd27);

  // Any transition back to T0 becomes HALT once a stop has been seen,
  // including a Stop arriving on this very edge.
  assign boundary_state = (stop_pending || Stop) ? S_HALT : S_T0;
  assign fsm_state = state;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= S_RST;
      stop_pending <= 1'b0;
    end else begin
      state <= next_state;
      if (Stop) stop_pending <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RST:  next_state = boundary_state;
      S_T0:   next_state = S_T1;
      S_T1:   next_state = S_T2;
      S_T2:   next_state = S_T3;
      S_T3: begin
        if (is_alu || is_muldiv) next_state = S_T4;
        else if (is_halt)        next_state = S_HALT;
        else                     next_state = boundary_state;
      end
      S_T4:   next_state = S_T5;
      S_T5:   next_state = is_muldiv ? S_T6 : boundary_state;
      S_T6:   next_state = boundary_state;
      S_HALT: next_state = S_HALT;
      default: next_state = S_RST;
    endcase
  end

  always_comb begin
    Run      = 1'b0;
    PCout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    PCin     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Rin      = 16'h0000;
    Rout     = 16'h0000;
    opcode   = 5'b00000;
    case (state)
      S_T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        Run = 1'b1;
        if (is_alu || is_muldiv) begin
          Rout = 16'h0001 << rb;
          Yin  = 1'b1;
        end
      end
      S_T4: begin
        Run    = 1'b1;
        Rout   = 16'h0001 << rc;
        Zin    = 1'b1;
        opcode = op;
      end
      S_T5: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        if (is_muldiv)   LOin = 1'b1;
        else if (is_alu) Rin  = 16'h0001 << ra;
      end
      S_T6: begin
        Run = 1'b1; Zhighout = 1'b1; HIin = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-state control words checked against
// hand-derived values, plus a per-cycle bus/one-hot checker.
module tb_control_unit;

  logic        Clock;
  logic        Reset;
  logic        Stop;
  logic [31:0] IR;
  logic        Run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
  logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read;
  logic [15:0] Rin, Rout;
  logic [4:0]  opcode;
  logic [3:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  // Control word bit positions, MSB first.
  localparam logic [16:0] B_RUN    = 17'h10000;
  localparam logic [16:0] B_PCOUT  = 17'h08000;
  localparam logic [16:0] B_ZHI    = 17'h04000;
  localparam logic [16:0] B_ZLO    = 17'h02000;
  localparam logic [16:0] B_MDROUT = 17'h01000;
  localparam logic [16:0] B_HIOUT  = 17'h00800;
  localparam logic [16:0] B_LOOUT  = 17'h00400;
  localparam logic [16:0] B_PCIN   = 17'h00200;
  localparam logic [16:0] B_MARIN  = 17'h00100;
  localparam logic [16:0] B_MDRIN  = 17'h00080;
  localparam logic [16:0] B_IRIN   = 17'h00040;
  localparam logic [16:0] B_YIN    = 17'h00020;
  localparam logic [16:0] B_ZIN    = 17'h00010;
  localparam logic [16:0] B_HIIN   = 17'h00008;
  localparam logic [16:0] B_LOIN   = 17'h00004;
  localparam logic [16:0] B_INC    = 17'h00002;
  localparam logic [16:0] B_READ   = 17'h00001;

  localparam logic [16:0] C_T0 = B_RUN | B_PCOUT | B_MARIN | B_INC | B_ZIN;
  localparam logic [16:0] C_T1 = B_RUN | B_ZLO | B_PCIN | B_READ | B_MDRIN;
  localparam logic [16:0] C_T2 = B_RUN | B_MDROUT | B_IRIN;
  localparam logic [16:0] C_T3 = B_RUN | B_YIN;
  localparam logic [16:0] C_T4 = B_RUN | B_ZIN;
  localparam logic [16:0] C_T5A = B_RUN | B_ZLO;
  localparam logic [16:0] C_T5M = B_RUN | B_ZLO | B_LOIN;
  localparam logic [16:0] C_T6 = B_RUN | B_ZHI | B_HIIN;

  logic [16:0] ctl;
  assign ctl = {Run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, PCin, MARin,
                MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read};

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR), .Run(Run),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .Rin(Rin), .Rout(Rout), .opcode(opcode),
    .fsm_state(fsm_state)
  );

  // Clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_now(input string tag, input logic [16:0] e_ctl,
                           input logic [15:0] e_rin, input logic [15:0] e_rout,
                           input logic [4:0] e_op);
    check({tag, ".ctl"},    {15'd0, ctl},  {15'd0, e_ctl});
    check({tag, ".rin"},    {16'd0, Rin},  {16'd0, e_rin});
    check({tag, ".rout"},   {16'd0, Rout}, {16'd0, e_rout});
    check({tag, ".opcode"}, {27'd0, opcode}, {27'd0, e_op});
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_tick(input string tag, input logic [16:0] e_ctl,
                             input logic [15:0] e_rin, input logic [15:0] e_rout,
                             input logic [4:0] e_op);
    check_now(tag, e_ctl, e_rin, e_rout, e_op);
    tick();
  endtask

  task automatic fetch(input string tag);
    expect_tick({tag, ".t0"}, C_T0, 16'h0, 16'h0, 5'b0);
    expect_tick({tag, ".t1"}, C_T1, 16'h0, 16'h0, 5'b0);
    expect_tick({tag, ".t2"}, C_T2, 16'h0, 16'h0, 5'b0);
  endtask

  // Leaves the bench 1 time unit after the edge that moved RST->T0.
  task automatic do_reset(input string tag);
    Reset = 1'b0;
    #2;
    check_now({tag, ".async"}, 17'h0, 16'h0, 16'h0, 5'b0);
    tick();
    tick();
    check_now({tag, ".held"}, 17'h0, 16'h0, 16'h0, 5'b0);
    Reset = 1'b1;
    #2;
    check_now({tag, ".rst_state"}, 17'h0, 16'h0, 16'h0, 5'b0);
    tick();
  endtask

  // Bus-driver and register-vector exclusivity in every cycle
  always @(negedge Clock) begin
    check("bus_drivers_le1",
          {31'd0, $countones({PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Rout}) <= 1},
          32'd1);
    check("rin_onehot0", {31'd0, $countones(Rin) <= 1}, 32'd1);
  end

  initial begin
    Reset = 1'b0;
    Stop  = 1'b0;
    IR    = 32'h0;
    #1;
    do_reset("reset0");

    // and R1,R2,R3
    IR = 32'h28918000;
    fetch("and");
    expect_tick("and.t3", C_T3,  16'h0000, 16'h0004, 5'b00000);
    expect_tick("and.t4", C_T4,  16'h0000, 16'h0008, 5'b00101);
    expect_tick("and.t5", C_T5A, 16'h0002, 16'h0000, 5'b00000);

    // mul R2,R3: seven cycles, result split over LO then HI
    IR = 32'h78118000;
    fetch("mul");
    expect_tick("mul.t3", C_T3,  16'h0000, 16'h0004, 5'b00000);
    expect_tick("mul.t4", C_T4,  16'h0000, 16'h0008, 5'b01111);
    expect_tick("mul.t5", C_T5M, 16'h0000, 16'h0000, 5'b00000);
    expect_tick("mul.t6", C_T6,  16'h0000, 16'h0000, 5'b00000);

    // illegal opcode: T3 is empty, straight back to fetch
    IR = 32'hF8000000;
    fetch("ill");
    expect_tick("ill.t3", B_RUN, 16'h0000, 16'h0000, 5'b00000);
    // nop behaves the same way
    IR = 32'hD0000000;
    fetch("nop");
    expect_tick("nop.t3", B_RUN, 16'h0000, 16'h0000, 5'b00000);

    // add with a one-cycle Stop pulse during T4: finish, then halt
    IR = 32'h18918000;
    fetch("stop4");
    expect_tick("stop4.t3", C_T3, 16'h0000, 16'h0004, 5'b00000);
    Stop = 1'b1;
    expect_tick("stop4.t4", C_T4, 16'h0000, 16'h0008, 5'b00011);
    Stop = 1'b0;
    expect_tick("stop4.t5", C_T5A, 16'h0002, 16'h0000, 5'b00000);
    for (int i = 0; i < 3; i++) expect_tick("stop4.halt", 17'h0, 16'h0, 16'h0, 5'b0);

    // Stop raised in T6 acts on the T6->T0 transition itself
    do_reset("reset1");
    IR = 32'h80118000;
    fetch("stop6");
    expect_tick("stop6.t3", C_T3,  16'h0000, 16'h0004, 5'b00000);
    expect_tick("stop6.t4", C_T4,  16'h0000, 16'h0008, 5'b10000);
    expect_tick("stop6.t5", C_T5M, 16'h0000, 16'h0000, 5'b00000);
    Stop = 1'b1;
    expect_tick("stop6.t6", C_T6,  16'h0000, 16'h0000, 5'b00000);
    Stop = 1'b0;
    for (int i = 0; i < 3; i++) expect_tick("stop6.halt", 17'h0, 16'h0, 16'h0, 5'b0);

    // halt instruction parks the block with everything low
    do_reset("reset2");
    IR = 32'hD8000000;
    fetch("halt");
    expect_tick("halt.t3", B_RUN, 16'h0000, 16'h0000, 5'b00000);
    for (int i = 0; i < 10; i++) expect_tick("halt.idle", 17'h0, 16'h0, 16'h0, 5'b0);

    // Reset in the middle of T4 kills the instruction immediately
    do_reset("reset3");
    IR = 32'h18918000;
    fetch("abort");
    expect_tick("abort.t3", C_T3, 16'h0000, 16'h0004, 5'b00000);
    check_now("abort.t4", C_T4, 16'h0000, 16'h0008, 5'b00011);
    #2;
    Reset = 1'b0;
    #1;
    check_now("abort.async", 17'h0, 16'h0, 16'h0, 5'b0);
    tick();
    check_now("abort.held", 17'h0, 16'h0, 16'h0, 5'b0);
    Reset = 1'b1;
    tick();
    expect_tick("abort.t0", C_T0, 16'h0, 16'h0, 5'b0);
    expect_tick("abort.t1", C_T1, 16'h0, 16'h0, 5'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
